// File: rtl/rr_free_list.sv
// Checkpointed physical-register free list for the rename stage.
// Grants are compacted in slot order. Branch checkpoints snapshot the head pointer so a mispredict can roll it back in one cycle.
module rr_free_list #(
  parameter int P_REGISTERS   = 64,
  parameter int L_REGISTERS   = 32,
  parameter int INSTR_COUNT   = 2,
  parameter int RELEASE_COUNT = 2,
  parameter int C_NUM         = 4
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [INSTR_COUNT-1:0]                      alloc_req_i,
  output logic [INSTR_COUNT*$clog2(P_REGISTERS)-1:0]  alloc_preg_o,
  output logic                                        alloc_ok_o,
  input  logic                                        ckpt_take_i,
  output logic [$clog2(C_NUM)-1:0]                    ckpt_id_o,
  output logic                                        ckpt_avail_o,
  input  logic                                        ckpt_commit_i,
  input  logic                                        restore_en_i,
  input  logic [$clog2(C_NUM)-1:0]                    restore_id_i,
  input  logic [RELEASE_COUNT-1:0]                    release_en_i,
  input  logic [RELEASE_COUNT*$clog2(P_REGISTERS)-1:0] release_preg_i,
  output logic [$clog2(P_REGISTERS-L_REGISTERS):0]    free_count_o,
  output logic                                        err_overflow_o
);

  localparam int FL_DEPTH = P_REGISTERS - L_REGISTERS;
  localparam int FW       = $clog2(FL_DEPTH);
  localparam int PW       = $clog2(P_REGISTERS);
  localparam int CW       = $clog2(C_NUM);

  logic [PW-1:0] fl_q [FL_DEPTH];
  logic [FW:0]   ck_q [C_NUM];
  logic [FW:0]   head_q, head_d, tail_q, tail_d, free_q, free_d;
  logic [CW:0]   ck_head_q, ck_head_d, ck_tail_q, ck_tail_d, ck_cnt_s, rst_tail_s;
  logic          err_q, err_d;
  logic [FW:0]   n_s, m_s;
  logic          grant_s, take_s, rel_ok_s;
  logic [FW-1:0] rel_idx_s [RELEASE_COUNT];

  function automatic logic [FW:0] popcnt_alloc(input logic [INSTR_COUNT-1:0] v);
    logic [FW:0] c;
    c = '0;
    for (int i = 0; i < INSTR_COUNT; i++) c = c + {{FW{1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [FW:0] popcnt_rel(input logic [RELEASE_COUNT-1:0] v);
    logic [FW:0] c;
    c = '0;
    for (int i = 0; i < RELEASE_COUNT; i++) c = c + {{FW{1'b0}}, v[i]};
    return c;
  endfunction

  // The k-th requesting slot reads entry head+k.
  always_comb begin
    logic [FW:0] k;
    k = '0;
    alloc_preg_o = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      alloc_preg_o[i*PW +: PW] = fl_q[head_q[FW-1:0] + k[FW-1:0]];
      k = k + {{FW{1'b0}}, alloc_req_i[i]};
    end
  end

  // Compacted write slots for returned registers.
  always_comb begin
    logic [FW:0] k;
    k = '0;
    for (int i = 0; i < RELEASE_COUNT; i++) begin
      rel_idx_s[i] = tail_q[FW-1:0] + k[FW-1:0];
      k = k + {{FW{1'b0}}, release_en_i[i]};
    end
  end

  // Grant, checkpoint availability and overflow decisions.
  always_comb begin
    n_s          = popcnt_alloc(alloc_req_i);
    m_s          = popcnt_rel(release_en_i);
    ck_cnt_s     = ck_tail_q - ck_head_q;
    ckpt_avail_o = (ck_cnt_s != (CW+1)'(C_NUM));
    ckpt_id_o    = ck_tail_q[CW-1:0];
    grant_s      = (n_s <= free_q) && (!ckpt_take_i || ckpt_avail_o) && !restore_en_i;
    alloc_ok_o   = grant_s && (n_s != '0);
    take_s       = ckpt_take_i && grant_s;
    rel_ok_s     = ({1'b0, free_q} + {1'b0, m_s}) <= (FW+2)'(FL_DEPTH);
  end

  // Pointer and flag next-state.
  always_comb begin
    head_d    = head_q;
    tail_d    = tail_q;
    ck_head_d = ck_head_q;
    ck_tail_d = ck_tail_q;
    err_d     = err_q;
    if (restore_en_i) begin
      head_d = ck_q[restore_id_i];
    end else if (grant_s) begin
      head_d = head_q + n_s;
    end else begin
      head_d = head_q;
    end
    if (rel_ok_s) begin
      tail_d = tail_q + m_s;
    end else begin
      err_d = 1'b1;
    end
    if (ckpt_commit_i && (ck_cnt_s != '0)) begin
      ck_head_d = ck_head_q + (CW+1)'(1);
    end else begin
      ck_head_d = ck_head_q;
    end
    // Rebuild the wrap bit relative to ck_head so the ring count stays valid.
    rst_tail_s = ck_head_q + {1'b0, restore_id_i - ck_head_q[CW-1:0]};
    if (restore_en_i) begin
      if ((rst_tail_s == ck_head_q) && (ck_head_d != ck_head_q)) begin
        ck_tail_d = ck_head_d;
      end else begin
        ck_tail_d = rst_tail_s;
      end
    end else if (take_s) begin
      ck_tail_d = ck_tail_q + (CW+1)'(1);
    end else begin
      ck_tail_d = ck_tail_q;
    end
    free_d = tail_d - head_d;
  end

  // Pointer, count and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= (FW+1)'(FL_DEPTH);
      free_q    <= (FW+1)'(FL_DEPTH);
      ck_head_q <= '0;
      ck_tail_q <= '0;
      err_q     <= 1'b0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      free_q    <= free_d;
      ck_head_q <= ck_head_d;
      ck_tail_q <= ck_tail_d;
      err_q     <= err_d;
    end
  end

  // Free-list storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FL_DEPTH; i++) fl_q[i] <= PW'(L_REGISTERS + i);
    end else begin
      for (int i = 0; i < RELEASE_COUNT; i++) begin
        if (rel_ok_s && release_en_i[i]) fl_q[rel_idx_s[i]] <= release_preg_i[i*PW +: PW];
      end
    end
  end

  // Checkpoint snapshots of the post-allocation head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < C_NUM; i++) ck_q[i] <= '0;
    end else if (take_s) begin
      ck_q[ck_tail_q[CW-1:0]] <= head_q + n_s;
    end
  end

  assign free_count_o   = free_q;
  assign err_overflow_o = err_q;

endmodule

// File: tb/tb_rr_free_list.sv
// Directed bench for rr_free_list: a cycle table plus hand sequences for exhaustion and async reset.
module tb_rr_free_list;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  alloc_req = 2'b00;
  logic [11:0] alloc_preg;
  logic        alloc_ok;
  logic        ckpt_take = 1'b0;
  logic [1:0]  ckpt_id;
  logic        ckpt_avail;
  logic        ckpt_commit = 1'b0;
  logic        restore_en = 1'b0;
  logic [1:0]  restore_id = 2'b00;
  logic [1:0]  release_en = 2'b00;
  logic [11:0] release_preg = 12'h000;
  logic [5:0]  free_count;
  logic        err_overflow;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    bit       rst_before;
    bit [1:0] req;
    bit       take, commit, restore;
    bit [1:0] rid, rel;
    bit [5:0] rp0, rp1;
    bit       ok;
    bit [5:0] p0, p1, free;
    bit       avail;
    bit [1:0] id;
    bit       err;
  } vec_t;

  vec_t tbl[$];

  rr_free_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_req_i(alloc_req), .alloc_preg_o(alloc_preg), .alloc_ok_o(alloc_ok),
    .ckpt_take_i(ckpt_take), .ckpt_id_o(ckpt_id), .ckpt_avail_o(ckpt_avail),
    .ckpt_commit_i(ckpt_commit), .restore_en_i(restore_en), .restore_id_i(restore_id),
    .release_en_i(release_en), .release_preg_i(release_preg),
    .free_count_o(free_count), .err_overflow_o(err_overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t v(bit r, bit [1:0] req, bit take, bit commit, bit restore, bit [1:0] rid,
                             bit [1:0] rel, bit [5:0] rp0, bit [5:0] rp1, bit ok, bit [5:0] p0,
                             bit [5:0] p1, bit [5:0] free, bit avail, bit [1:0] id, bit err);
    vec_t t;
    t.rst_before = r; t.req = req; t.take = take; t.commit = commit; t.restore = restore;
    t.rid = rid; t.rel = rel; t.rp0 = rp0; t.rp1 = rp1; t.ok = ok; t.p0 = p0; t.p1 = p1;
    t.free = free; t.avail = avail; t.id = id; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_req = 2'b00; ckpt_take = 1'b0; ckpt_commit = 1'b0; restore_en = 1'b0;
    restore_id = 2'b00; release_en = 2'b00; release_preg = 12'h000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input vec_t t, input string tag);
    @(negedge clk);
    alloc_req = t.req; ckpt_take = t.take; ckpt_commit = t.commit; restore_en = t.restore;
    restore_id = t.rid; release_en = t.rel; release_preg = {t.rp1, t.rp0};
    #1;
    chk({tag, ".alloc_ok"}, int'(alloc_ok), int'(t.ok));
    if (t.ok && t.req[0]) chk({tag, ".preg0"}, int'(alloc_preg[5:0]), int'(t.p0));
    if (t.ok && t.req[1]) chk({tag, ".preg1"}, int'(alloc_preg[11:6]), int'(t.p1));
    chk({tag, ".free_count"}, int'(free_count), int'(t.free));
    chk({tag, ".ckpt_avail"}, int'(ckpt_avail), int'(t.avail));
    chk({tag, ".ckpt_id"}, int'(ckpt_id), int'(t.id));
    chk({tag, ".err_overflow"}, int'(err_overflow), int'(t.err));
  endtask

  initial begin
    // Reset state, first allocation, compaction.
    tbl.push_back(v(1, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 32, 1, 0, 0));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 32,33, 32, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 30, 1, 0, 0));
    tbl.push_back(v(0, 2'b10, 0,0,0,2'd0, 2'b00, 0,0, 1, 0, 34, 30, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 29, 1, 0, 0));
    // Checkpoint then restore.
    tbl.push_back(v(1, 2'b11, 1,0,0,2'd0, 2'b00, 0,0, 1, 32,33, 32, 1, 0, 0));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 34,35, 30, 1, 1, 0));
    tbl.push_back(v(0, 2'b11, 0,0,1,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 1, 0));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 34,35, 30, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 0, 0));
    // Fill the checkpoint ring, blocked take, commit.
    tbl.push_back(v(0, 2'b00, 1,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 1,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 1, 0));
    tbl.push_back(v(0, 2'b00, 1,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 2, 0));
    tbl.push_back(v(0, 2'b00, 1,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 3, 0));
    tbl.push_back(v(0, 2'b11, 1,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,1,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 0, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 0, 0));
    // Take with commit, then restore to a mid-ring id together with a release.
    tbl.push_back(v(0, 2'b01, 1,1,0,2'd0, 2'b00, 0,0, 1, 36, 0, 28, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 27, 1, 1, 0));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 37,38, 27, 1, 1, 0));
    tbl.push_back(v(0, 2'b00, 0,0,1,2'd0, 2'b01, 10,0, 0, 0, 0, 25, 1, 1, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 28, 1, 0, 0));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 37,38, 28, 1, 0, 0));
    // Overflow is dropped and sticky.
    tbl.push_back(v(1, 2'b00, 0,0,0,2'd0, 2'b01, 9,0, 0, 0, 0, 32, 1, 0, 0));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 32, 1, 0, 1));
    tbl.push_back(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 32,33, 32, 1, 0, 1));
    tbl.push_back(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 30, 1, 0, 1));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_before) do_reset();
      step(tbl[i], $sformatf("row%0d", i));
    end

    // Asynchronous reset takes effect between edges.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.free_count", int'(free_count), 32);
    chk("async_rst.err_overflow", int'(err_overflow), 0);
    chk("async_rst.ckpt_id", int'(ckpt_id), 0);

    // Exhaust the list, then recycle through the wrapped tail.
    do_reset();
    for (int i = 0; i < 16; i++)
      step(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 6'(32+2*i), 6'(33+2*i), 6'(32-2*i), 1, 0, 0),
           $sformatf("exh%0d", i));
    step(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 0, 1, 0, 0), "exh_empty");
    step(v(0, 2'b01, 0,0,0,2'd0, 2'b11, 5,7, 0, 0, 0, 0, 1, 0, 0), "exh_blocked");
    step(v(0, 2'b11, 0,0,0,2'd0, 2'b00, 0,0, 1, 5, 7, 2, 1, 0, 0), "exh_recycle");
    step(v(0, 2'b00, 0,0,0,2'd0, 2'b00, 0,0, 0, 0, 0, 0, 1, 0, 0), "exh_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
